// File: rtl/spell_gpio_pkg.sv
// Shared constants for the SPELL GPIO bank: register offsets and bus defaults.
package spell_gpio_pkg;

  localparam int unsigned PORT_W        = 8;
  localparam int unsigned REGS_PER_PORT = 4;
  localparam int unsigned MAX_PORTS     = 8;

  // Per-port register offsets, relative to BASE_ADDR + 4*i
  localparam logic [1:0] OFF_PIN   = 2'd0;
  localparam logic [1:0] OFF_DDR   = 2'd1;
  localparam logic [1:0] OFF_PORT  = 2'd2;
  localparam logic [1:0] OFF_PCMSK = 2'd3;

  // Global register offsets, relative to BASE_ADDR + 4*NUM_PORTS
  localparam logic [1:0] OFF_PCICR = 2'd0;
  localparam logic [1:0] OFF_PCIFR = 2'd1;

  // Read value returned for addresses outside the bank
  localparam logic [PORT_W-1:0] UNMAPPED_RD = 8'hFF;

endpackage

// File: rtl/spell_gpio_port.sv
// One 8-bit GPIO port: pad synchroniser, change history, DDR/PORT/PCMSK registers.
module spell_gpio_port
  import spell_gpio_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PORT_W-1:0] i_pad,
  input  logic [PORT_W-1:0] i_wdata,
  input  logic              i_wr_ddr,
  input  logic              i_wr_port,
  input  logic              i_wr_pcmsk,
  input  logic              i_tgl_pin,
  output logic [PORT_W-1:0] o_pin,
  output logic [PORT_W-1:0] o_ddr,
  output logic [PORT_W-1:0] o_port,
  output logic [PORT_W-1:0] o_pcmsk,
  output logic              o_chg_c
);

  logic [PORT_W-1:0] r_sync1;
  logic [PORT_W-1:0] r_sync2;
  logic [PORT_W-1:0] r_hist;
  logic [PORT_W-1:0] r_ddr;
  logic [PORT_W-1:0] r_port;
  logic [PORT_W-1:0] r_pcmsk;

  // Two-flop pad synchroniser plus one stage of history for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
    end else begin
      r_sync1 <= i_pad;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // Control registers; a PIN write toggles PORT bits instead of loading them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ddr   <= '0;
      r_port  <= '0;
      r_pcmsk <= '0;
    end else begin
      if (i_wr_ddr) begin
        r_ddr <= i_wdata;
      end
      if (i_wr_port) begin
        r_port <= i_wdata;
      end else if (i_tgl_pin) begin
        r_port <= r_port ^ i_wdata;
      end
      if (i_wr_pcmsk) begin
        r_pcmsk <= i_wdata;
      end
    end
  end

  assign o_pin   = r_sync2;
  assign o_ddr   = r_ddr;
  assign o_port  = r_port;
  assign o_pcmsk = r_pcmsk;
  assign o_chg_c = |((r_sync2 ^ r_hist) & r_pcmsk);

endmodule

// File: rtl/spell_gpio_bank.sv
// SPELL data-memory-bus GPIO bank: NUM_PORTS ports, pin-change flags and irq.
module spell_gpio_bank
  import spell_gpio_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter logic [7:0]  BASE_ADDR = 8'h30
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          select,
  input  logic [7:0]                    addr,
  input  logic [PORT_W-1:0]             data_in,
  input  logic                          write,
  output logic [PORT_W-1:0]             data_out,
  output logic                          data_ready,
  input  logic [PORT_W*NUM_PORTS-1:0]   port_in,
  output logic [PORT_W*NUM_PORTS-1:0]   port_out,
  output logic [PORT_W*NUM_PORTS-1:0]   port_oe,
  output logic                          irq
);

  localparam int unsigned NUM_PORT_REGS = REGS_PER_PORT * NUM_PORTS;

  if (NUM_PORTS < 1 || NUM_PORTS > MAX_PORTS) begin : g_bad_num_ports
    $error("spell_gpio_bank: NUM_PORTS out of range 1..8");
  end
  if ((int'(BASE_ADDR) + int'(NUM_PORT_REGS) + 1) > 255) begin : g_bad_base
    $error("spell_gpio_bank: register window exceeds address space");
  end

  logic [8:0]           w_off;
  logic [2:0]           w_idx;
  logic [1:0]           w_reg;
  logic                 w_in_port;
  logic                 w_in_glb;
  logic                 w_wr;
  logic                 w_pcicr_we;
  logic                 w_pcifr_we;
  logic [NUM_PORTS-1:0] w_pcifr_clr;
  logic [NUM_PORTS-1:0] w_chg;
  logic [PORT_W-1:0]    w_rd_data;
  logic [PORT_W-1:0]    w_pin   [NUM_PORTS];
  logic [PORT_W-1:0]    w_ddr   [NUM_PORTS];
  logic [PORT_W-1:0]    w_port  [NUM_PORTS];
  logic [PORT_W-1:0]    w_pcmsk [NUM_PORTS];

  logic                 r_past_wr;
  logic [NUM_PORTS-1:0] r_pcicr;
  logic [NUM_PORTS-1:0] r_pcifr;
  logic                 r_irq;
  logic [PORT_W-1:0]    r_data_out;
  logic                 r_data_ready;

  // Address decode; 9-bit subtraction makes addresses below the base fall out of range
  assign w_off      = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign w_idx      = w_off[4:2];
  assign w_reg      = w_off[1:0];
  assign w_in_port  = (w_off < 9'(NUM_PORT_REGS));
  assign w_in_glb   = (w_off == 9'(NUM_PORT_REGS)) || (w_off == 9'(NUM_PORT_REGS + 1));
  assign w_wr       = select && write;
  assign w_pcicr_we = w_wr && w_in_glb && (w_reg == OFF_PCICR);
  assign w_pcifr_we = w_wr && w_in_glb && (w_reg == OFF_PCIFR);
  assign w_pcifr_clr = w_pcifr_we ? data_in[NUM_PORTS-1:0] : '0;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic w_hit;
    assign w_hit = w_wr && w_in_port && (w_idx == 3'(i));

    spell_gpio_port u_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_pad      (port_in[PORT_W*i +: PORT_W]),
      .i_wdata    (data_in),
      .i_wr_ddr   (w_hit && (w_reg == OFF_DDR)),
      .i_wr_port  (w_hit && (w_reg == OFF_PORT)),
      .i_wr_pcmsk (w_hit && (w_reg == OFF_PCMSK)),
      .i_tgl_pin  (w_hit && (w_reg == OFF_PIN) && !r_past_wr),
      .o_pin      (w_pin[i]),
      .o_ddr      (w_ddr[i]),
      .o_port     (w_port[i]),
      .o_pcmsk    (w_pcmsk[i]),
      .o_chg_c    (w_chg[i])
    );

    assign port_out[PORT_W*i +: PORT_W] = w_port[i];
    assign port_oe[PORT_W*i +: PORT_W]  = w_ddr[i];
  end

  // Read data mux over the addressed register
  always_comb begin
    w_rd_data = UNMAPPED_RD;
    if (w_in_port) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (w_idx == 3'(i)) begin
          case (w_reg)
            OFF_PIN:   w_rd_data = w_pin[i];
            OFF_DDR:   w_rd_data = w_ddr[i];
            OFF_PORT:  w_rd_data = w_port[i];
            OFF_PCMSK: w_rd_data = w_pcmsk[i];
            default:   w_rd_data = UNMAPPED_RD;
          endcase
        end
      end
    end else if (w_in_glb) begin
      w_rd_data = (w_reg == OFF_PCIFR) ? PORT_W'(r_pcifr) : PORT_W'(r_pcicr);
    end
  end

  // Bus response and write-burst tracking for the once-per-burst PIN toggle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_ready <= 1'b0;
      r_data_out   <= '0;
      r_past_wr    <= 1'b0;
    end else begin
      r_data_ready <= select;
      r_data_out   <= (select && !write) ? w_rd_data : '0;
      r_past_wr    <= w_wr;
    end
  end

  // Pin-change enable/flags; a new change wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pcicr <= '0;
      r_pcifr <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_pcicr_we) begin
        r_pcicr <= data_in[NUM_PORTS-1:0];
      end
      r_pcifr <= (r_pcifr & ~w_pcifr_clr) | (w_chg & r_pcicr);
      r_irq   <= |(r_pcifr & r_pcicr);
    end
  end

  assign data_out   = r_data_out;
  assign data_ready = r_data_ready;
  assign irq        = r_irq;

endmodule

// File: tb/tb_spell_gpio_bank.sv
// Randomised scoreboard bench for spell_gpio_bank against a behavioural model.
module tb_spell_gpio_bank;

  localparam int unsigned N    = 2;
  localparam int unsigned W    = 8 * N;
  localparam logic [7:0]  BASE = 8'h30;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         select = 1'b0;
  logic [7:0]   addr = '0;
  logic [7:0]   data_in = '0;
  logic         write = 1'b0;
  logic [7:0]   data_out;
  logic         data_ready;
  logic [W-1:0] port_in = '0;
  logic [W-1:0] port_out;
  logic [W-1:0] port_oe;
  logic         irq;

  spell_gpio_bank #(.NUM_PORTS(N), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .select     (select),
    .addr       (addr),
    .data_in    (data_in),
    .write      (write),
    .data_out   (data_out),
    .data_ready (data_ready),
    .port_in    (port_in),
    .port_out   (port_out),
    .port_oe    (port_oe),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         dr;
    logic         chk_dout;
    logic [W-1:0] po;
    logic [W-1:0] oe;
    logic         irq;
  } cyc_t;

  cyc_t       cyc_q[$];
  logic [7:0] rsp_q[$];
  int         checks = 0;
  int         errors = 0;

  // Behavioural model: register file as arrays, pad pipeline as a history of
  // sampled pad words (index 0 = sampled this edge, 1 = one edge ago, ...).
  logic [7:0]   m_ddr   [N];
  logic [7:0]   m_port  [N];
  logic [7:0]   m_pcmsk [N];
  int unsigned  m_pcicr;
  int unsigned  m_pcifr;
  bit           m_past_wr;
  bit           m_irq;
  logic [W-1:0] pad_hist[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pin_of(input int p);
    logic [W-1:0] v;
    v = pad_hist[1];
    return v[8*p +: 8];
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int off;
    off = int'(a) - int'(BASE);
    if (off >= 0 && off < 4 * int'(N)) begin
      case (off % 4)
        0:       return pin_of(off / 4);
        1:       return m_ddr[off / 4];
        2:       return m_port[off / 4];
        default: return m_pcmsk[off / 4];
      endcase
    end
    if (off == 4 * int'(N))     return 8'(m_pcicr);
    if (off == 4 * int'(N) + 1) return 8'(m_pcifr);
    return 8'hFF;
  endfunction

  // Advance the model across one clock edge and queue what the DUT must show after it
  task automatic model_edge(input bit r, input bit s, input bit w,
                            input logic [7:0] a, input logic [7:0] d, input logic [W-1:0] pad);
    cyc_t        c;
    int          off;
    int unsigned set_m;
    int unsigned clr_m;
    int unsigned mask;
    logic [W-1:0] cur, prev;
    logic [7:0]  rd;
    mask = (1 << N) - 1;
    if (!r) begin
      for (int p = 0; p < int'(N); p++) begin
        m_ddr[p] = '0; m_port[p] = '0; m_pcmsk[p] = '0;
      end
      m_pcicr = 0; m_pcifr = 0; m_past_wr = 0; m_irq = 0;
      pad_hist = '{'0, '0, '0};
      c = '{dr: 1'b0, chk_dout: 1'b1, po: '0, oe: '0, irq: 1'b0};
      cyc_q.push_back(c);
      return;
    end
    rd = m_read(a);
    cur = pad_hist[1];
    prev = pad_hist[2];
    set_m = 0;
    for (int p = 0; p < int'(N); p++) begin
      if ((((cur[8*p +: 8] ^ prev[8*p +: 8]) & m_pcmsk[p]) != 0) && m_pcicr[p])
        set_m |= (1 << p);
    end
    m_irq = (m_pcifr & m_pcicr) != 0;
    clr_m = 0;
    if (s && w) begin
      off = int'(a) - int'(BASE);
      if (off >= 0 && off < 4 * int'(N)) begin
        case (off % 4)
          0:       if (!m_past_wr) m_port[off / 4] = m_port[off / 4] ^ d;
          1:       m_ddr[off / 4] = d;
          2:       m_port[off / 4] = d;
          default: m_pcmsk[off / 4] = d;
        endcase
      end else if (off == 4 * int'(N)) begin
        m_pcicr = int'(d) & mask;
      end else if (off == 4 * int'(N) + 1) begin
        clr_m = int'(d) & mask;
      end
    end
    m_pcifr = ((m_pcifr & ~clr_m) | set_m) & mask;
    m_past_wr = s && w;
    pad_hist.push_front(pad);
    void'(pad_hist.pop_back());
    if (s) rsp_q.push_back(w ? 8'h00 : rd);
    c.dr = s;
    c.chk_dout = 1'b0;
    c.irq = m_irq;
    for (int p = 0; p < int'(N); p++) begin
      c.po[8*p +: 8] = m_port[p];
      c.oe[8*p +: 8] = m_ddr[p];
    end
    cyc_q.push_back(c);
  endtask

  task automatic drive(input bit r, input bit s, input bit w,
                       input logic [7:0] a, input logic [7:0] d, input logic [W-1:0] pad);
    @(negedge clk);
    rst_n = r; select = s; write = w; addr = a; data_in = d; port_in = pad;
    model_edge(r, s, w, a, d, pad);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1, 0, 0, 8'h00, 8'h00, port_in);
  endtask

  // Monitor: one expected state per edge; bus responses popped on data_ready
  initial begin : monitor
    cyc_t       c;
    logic [7:0] e;
    wait (cyc_q.size() > 0);
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() == 0) begin
        check("cycle_queue_underflow", 32'd1, 32'd0);
      end else begin
        c = cyc_q.pop_front();
        check("data_ready", 32'(data_ready), 32'(c.dr));
        check("port_out", 32'(port_out), 32'(c.po));
        check("port_oe", 32'(port_oe), 32'(c.oe));
        check("irq", 32'(irq), 32'(c.irq));
        if (c.chk_dout) check("data_out_reset", 32'(data_out), 32'h0);
      end
      if (data_ready === 1'b1) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_response", 32'd1, 32'd0);
        end else begin
          e = rsp_q.pop_front();
          check("data_out", 32'(data_out), 32'(e));
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomised traffic
  initial begin : stimulus
    logic         s, w, r;
    logic [7:0]   a, d;
    logic [W-1:0] pad;
    pad_hist = '{'0, '0, '0};
    drive(0, 0, 0, 8'h00, 8'h00, '0);
    drive(0, 0, 0, 8'h00, 8'h00, '0);
    drive(1, 1, 0, BASE + 8'd1, 8'h00, '0);
    idle(1);
    // port 1 direction and output value
    drive(1, 1, 1, BASE + 8'd5, 8'h0F, '0);
    drive(1, 1, 1, BASE + 8'd6, 8'hA5, '0);
    drive(1, 1, 0, BASE + 8'd5, 8'h00, '0);
    drive(1, 1, 0, BASE + 8'd6, 8'h00, '0);
    idle(1);
    // PIN write toggles PORT once per burst
    drive(1, 1, 1, BASE + 8'd2, 8'h3C, '0);
    idle(1);
    for (int k = 0; k < 3; k++) drive(1, 1, 1, BASE, 8'hFF, '0);
    drive(1, 1, 0, BASE + 8'd2, 8'h00, '0);
    drive(1, 1, 1, BASE, 8'hFF, '0);
    drive(1, 1, 0, BASE + 8'd2, 8'h00, '0);
    // synchroniser latency
    idle(1);
    drive(1, 0, 0, 8'h00, 8'h00, 16'h005A);
    for (int k = 0; k < 3; k++) drive(1, 1, 0, BASE, 8'h00, 16'h005A);
    drive(1, 0, 0, 8'h00, 8'h00, 16'h0000);
    idle(4);
    // pin-change interrupt, mask, W1C and set-beats-clear
    drive(1, 1, 1, BASE + 8'd3, 8'h01, '0);
    drive(1, 1, 1, BASE + 8'd8, 8'h01, '0);
    idle(2);
    drive(1, 0, 0, 8'h00, 8'h00, 16'h0001);
    idle(4);
    drive(1, 1, 0, BASE + 8'd9, 8'h00, 16'h0001);
    drive(1, 0, 0, 8'h00, 8'h00, 16'h0003);
    idle(4);
    drive(1, 1, 1, BASE + 8'd9, 8'h01, 16'h0003);
    idle(2);
    drive(1, 0, 0, 8'h00, 8'h00, 16'h0002);
    idle(1);
    drive(1, 1, 1, BASE + 8'd9, 8'h01, 16'h0002);
    drive(1, 1, 0, BASE + 8'd9, 8'h00, 16'h0002);
    idle(3);
    // unmapped addresses
    drive(1, 1, 0, 8'h00, 8'h00, 16'h0002);
    drive(1, 1, 0, 8'hFF, 8'h00, 16'h0002);
    drive(1, 1, 1, 8'h00, 8'h55, 16'h0002);
    drive(1, 1, 0, BASE + 8'd6, 8'h00, 16'h0002);
    // reset in the middle of a write
    drive(0, 1, 1, BASE + 8'd6, 8'h11, 16'h0002);
    drive(1, 1, 0, BASE + 8'd6, 8'h00, 16'h0002);
    // randomised traffic
    s = 0; w = 0; a = BASE; d = 0; pad = '0;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 3) != 0) begin
        s = ($urandom_range(0, 9) < 7);
        w = $urandom_range(0, 1);
        d = 8'($urandom);
        case ($urandom_range(0, 9))
          0:       a = 8'($urandom);
          1:       a = a;
          default: a = BASE + 8'($urandom_range(0, 4 * N + 1));
        endcase
      end
      if ($urandom_range(0, 9) < 3) pad = pad ^ W'($urandom);
      drive(r, s, w, a, d, pad);
    end
    idle(3);
    @(posedge clk);
    #2;
    check("responses_drained", 32'(rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spell_gpio_bank.md
Name: spell_gpio_bank

Overview:
- Parametrised GPIO register bank on the SPELL core's data-memory I/O bus; next generation of the single-port I/O block.
- Provides NUM_PORTS 8-bit ports, each with PIN/DDR/PORT registers, a 2-flop input synchroniser, a per-bit pin-change mask, and a combined pin-change interrupt request.
- Same select/write/data_ready bus handshake as the existing I/O block, so it drops into the same slot.

Parameters:
- NUM_PORTS, 2, number of 8-bit ports; legal range 1..8.
- BASE_ADDR, 8'h30, address of port 0 PIN; BASE_ADDR+4*NUM_PORTS+1 must be <= 8'hFF.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- select  in  1  bus access strobe, this cycle
- addr  in  8  register address
- data_in  in  8  write data
- write  in  1  1=write, 0=read (qualified by select)
- data_out  out  8  read data, registered
- data_ready  out  1  access acknowledge, registered
- port_in  in  8*NUM_PORTS  raw asynchronous pad inputs; port i = bits [8i+7:8i]
- port_out  out  8*NUM_PORTS  output values
- port_oe  out  8*NUM_PORTS  output enables, active high
- irq  out  1  level interrupt request, registered

Behaviour:
- Register map, port i, base a = BASE_ADDR+4*i:
  - a+0 PIN: read returns synchronised input; write XORs data_in into PORT.
  - a+1 DDR: r/w, drives port_oe.
  - a+2 PORT: r/w, drives port_out.
  - a+3 PCMSK: r/w pin-change mask.
- Global registers, g = BASE_ADDR+4*NUM_PORTS:
  - g+0 PCICR: r/w; bit i enables port i; bits >= NUM_PORTS read 0, writes ignored.
  - g+1 PCIFR: flag bit i per port; read returns flags; write-1-to-clear.
- Any other address: read returns 8'hFF; write has no effect. data_ready still asserts.
- Reset (rst_n=0 at clk edge) clears every register, synchroniser, edge-detect history, data_out, data_ready and irq to 0. This applies mid-access too: no partial write survives.
- Handshake:
  - select=1 at edge N gives data_ready=1 after edge N; select=0 gives data_ready=0.
  - Read: data_out valid in the same cycle as data_ready. On a write, data_out=0.
  - Back-to-back selects are accepted every cycle.
- PIN toggle: applied once per contiguous write burst. A past_write flop records select&write. The toggle happens only when past_write=0.
  - DDR/PORT/PCMSK/PCICR writes apply on every selected write cycle.
- Synchroniser: sync1 <= port_in; sync2 <= sync1; hist <= sync2. PIN read returns sync2.
  - Latency: a pad change at edge N is readable from a read issued at edge N+2, with data_out updated at N+2.
- Pin change: chg_i = |((sync2_i ^ hist_i) & PCMSK_i).
  - If chg_i and PCICR[i], PCIFR[i] <= 1 at that edge.
  - Set beats a same-cycle W1C of the same bit.
  - PCIFR is not set while PCICR[i]=0; earlier history is not retained.
- irq <= |(PCIFR & PCICR), registered. It deasserts the cycle after the clearing write, unless a new change occurred.
- A PORT write and a PIN toggle in the same cycle cannot occur: one address per access.

Decomposition:
- Shared package spell_gpio_pkg holds:
  - register offset constants: OFF_PIN=0, OFF_DDR=1, OFF_PORT=2, OFF_PCMSK=3, OFF_PCICR=0, OFF_PCIFR=1;
  - the unmapped read value 8'hFF.
- Sub-module spell_gpio_port, instantiated NUM_PORTS times via generate. It contains one port's synchroniser, history, DDR/PORT/PCMSK registers and the chg output.
- Top level contains address decode, past_write, PCICR/PCIFR, the read mux and irq.

Test Plan:
- Reset: after rst_n low 2 cycles, all outputs 0. Read BASE+1 -> data_out=00, data_ready=1 one cycle after select.
- Port 1 (N=2): write DDR 0x0F at 0x35 and PORT 0xA5 at 0x36 -> port_out[15:8]=A5, port_oe[15:8]=0F. Read-back returns the same values.
- PIN toggle: PORT0=0x3C. Hold select&write on 0x30 with data 0xFF for 3 cycles -> PORT0=0xC3 (single toggle). A separate second write -> 0x3C.
- Synchroniser: drive port_in[7:0] 00->5A at edge N. A read of 0x30 at N+1 returns 00; a read at N+2 returns 5A.
- Interrupt:
  - PCMSK0=0x01, PCICR=0x01 (0x38). Toggle pad bit0 -> PCIFR=01 and irq=1 within 4 cycles.
  - Toggle bit1 -> no new flag.
  - W1C 0x01 at 0x39 -> irq=0 the next cycle.
  - Flag set coincident with W1C -> flag stays 1.
- Unmapped: read 0x00 and 0xFF -> data_out=FF, data_ready=1. Write to 0x00 -> no register changes.
